uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

UART transmit engine that serialises one byte per request into an 8-bit frame, with optional parity and 1 or 2 stop bits. It is the responder on the Tx_En_Sig / Tx_Data / Tx_Done_Sig handshake driven by the rx/tx connect controller. It drives the FPGA UART TX pin directly.

## Interface

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- CLK  in  1  system clock; all logic runs on its rising edge.
- RST_n  in  1  synchronous active-low reset; sampled on the rising edge of CLK.
- Tx_En_Sig  in  1  transmit request, level; held high by the initiator until it sees Tx_Done_Sig.
- Tx_Data  in  8  byte to send; sampled only on the start edge.
- Tx_Done_Sig  out  1  one-cycle pulse after the last stop bit completes.
- Tx_Busy  out  1  high whenever state ≠ IDLE.
- TX_Pin_Out  out  1  serial line; idles high.

## Operation

- BPS = (CLK_FREQ + BAUD/2) / BAUD, integer. Elaboration fails if BPS < 2, PARITY > 2, or STOP_BITS is not 1 or 2.
- Frame order is start(0), D0..D7 (LSB first), optional parity, then stop(1) × STOP_BITS. NBITS = 9 + (PARITY≠0) + STOP_BITS.
- Odd parity: the parity bit makes the total count of ones in D0..D7 plus parity odd. Even parity: the total is even.
- States and transitions:
  - IDLE: if Tx_En_Sig=1, latch Tx_Data into the shift register, compute parity, and go to START.
  - START → DATA → PARITY (skipped if PARITY=0) → STOP.
  - STOP → DONE.
  - DONE → IDLE unconditionally, after one cycle.
- Each of START, DATA bit, PARITY and STOP bit lasts exactly BPS cycles, timed by a 0..BPS-1 counter. A 3-bit index counts the data bits; a 1-bit index counts the stop bits.
- Reset values: TX_Pin_Out=1, Tx_Done_Sig=0, Tx_Busy=0, state=IDLE, counters=0, shift register=8'h00.
- Boundary rules:
  - Tx_Data changes mid-frame: ignored; the latched byte is sent.
  - Tx_En_Sig drops mid-frame: the frame completes and Tx_Done_Sig still pulses.
  - Tx_En_Sig still high in the first IDLE cycle after DONE: a new frame starts. The initiator must deassert Tx_En_Sig on the edge at which it samples Tx_Done_Sig.
  - RST_n low mid-frame: on the next edge, all outputs take their reset values and no Tx_Done_Sig is issued for the aborted frame.
  - Bit counter wrap: the counter reloads to 0 at BPS-1. There is no drift across bits.

## Timing

- Edge e0 is the edge at which IDLE samples Tx_En_Sig=1. Cycle k means the cycle after edge e0+k-1.
- TX_Pin_Out is registered:
  - start bit occupies cycles 1..BPS;
  - bit j occupies cycles j·BPS+1..(j+1)·BPS.
- Tx_Busy is high in cycles 1..NBITS·BPS+1.
- Tx_Done_Sig is high for exactly cycle NBITS·BPS+1, with TX_Pin_Out=1 during that cycle.
- IDLE resumes at cycle NBITS·BPS+2. The earliest next start edge ends that cycle.
- Request-to-start-bit latency is 1 cycle.

## Structure

- Shared package uart_pkg:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP, DONE; 3 bits);
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - a calc_bps(CLK_FREQ, BAUD) function, reused by the receiver.
- One sub-module, uart_baud_tick:
  - BPS-cycle counter with a synchronous clear;
  - emits an end-of-bit strobe in the counter's BPS-1 cycle.
- Everything else stays in uart_tx_engine.

## Test plan

All scenarios use CLK_FREQ=160, BAUD=10 (BPS=16) unless stated otherwise.

- Reset check: hold RST_n=0 for 5 cycles with Tx_En_Sig=1 → TX_Pin_Out=1, Tx_Busy=0, Tx_Done_Sig=0 throughout; the first frame starts 1 cycle after release.
- 8N1 frame: PARITY=0, STOP_BITS=1, send 8'hA5 → the line reads 0,1,0,1,0,0,1,0,1,1, each bit for 16 cycles; Tx_Done_Sig is high only at cycle 161.
- Parity frames:
  - PARITY=1, STOP_BITS=2, send 8'h07 → parity bit=0; frame is 12 bits; Done at cycle 193.
  - PARITY=2, send 8'h07 → parity bit=1.
- Mid-frame input changes: change Tx_Data to 8'hFF and drop Tx_En_Sig at cycle 40 while sending 8'h3C → 8'h3C is sent intact and Done still pulses.
- Handshake with a connect-style initiator:
  - initiator drops En one edge after Done → exactly one frame per request;
  - initiator holds En high → back-to-back frames, with start bits at cycles 1 and 163.
- Reset during data bit 4 → the pin goes high on the next edge, no Done is issued, and a new request afterwards produces a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and the
// baud divisor helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int calc_bps(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

  function automatic logic calcParity(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BPS-1 while running and strobes tick_o in the
// final cycle of each bit so the frame FSM advances exactly on bit boundaries.
module uart_baud_tick #(
  parameter int BPS = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Reload at the last count so every bit is exactly BPS cycles with no drift.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: serialises one latched byte per request as
// start, D0..D7, optional parity and 1 or 2 stop bits, then pulses Tx_Done_Sig.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       Tx_En_Sig,
  input  logic [7:0] Tx_Data,
  output logic       Tx_Done_Sig,
  output logic       Tx_Busy,
  output logic       TX_Pin_Out
);

  localparam int   BPS       = calc_bps(CLK_FREQ, BAUD);
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  if (BPS < 2 || PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : gen_param_check
    $error("uart_tx_engine: illegal parameter combination");
  end

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bitIdx_q;
  logic        stopIdx_q;
  logic        parity_q;
  logic        pin_q;
  logic        done_q;
  logic        busy_q;
  logic        bitTick;
  logic        tickClr;

  // The timer is held at zero whenever no bit is on the line.
  assign tickClr = (state_q == ST_IDLE) || (state_q == ST_DONE);

  uart_baud_tick #(
    .BPS(BPS)
  ) u_baud_tick (
    .clk_i  (CLK),
    .rst_ni (RST_n),
    .clr_i  (tickClr),
    .tick_o (bitTick)
  );

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bitIdx_q  <= 3'd0;
      stopIdx_q <= 1'b0;
      parity_q  <= 1'b0;
      pin_q     <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Tx_En_Sig) begin
            shift_q   <= Tx_Data;
            parity_q  <= calcParity(Tx_Data, PARITY);
            bitIdx_q  <= 3'd0;
            stopIdx_q <= 1'b0;
            pin_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (bitTick) begin
            pin_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= ST_DATA;
          end
        end
        // The pin value for the next bit is loaded on the tick so the line stays registered.
        ST_DATA: begin
          if (bitTick) begin
            if (bitIdx_q == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                pin_q   <= parity_q;
                state_q <= ST_PARITY;
              end else begin
                pin_q   <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              pin_q    <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bitTick) begin
            pin_q   <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bitTick) begin
            if (stopIdx_q == STOP_LAST) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              stopIdx_q <= stopIdx_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          pin_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign TX_Pin_Out  = pin_q;
  assign Tx_Done_Sig = done_q;
  assign Tx_Busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: three instances (8N1, odd/2-stop, even/1-stop)
// checked cycle by cycle against a frame model built from the byte and framing options.
module tb_uart_tx_engine;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int BPS      = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic [2:0] en;
  logic [7:0] data [0:2];
  wire  [2:0] pin;
  wire  [2:0] busy;
  wire  [2:0] done;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(0), .STOP_BITS(1)) dut8n1 (
    .CLK(clk), .RST_n(rstN), .Tx_En_Sig(en[0]), .Tx_Data(data[0]),
    .Tx_Done_Sig(done[0]), .Tx_Busy(busy[0]), .TX_Pin_Out(pin[0]));

  uart_tx_engine #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(1), .STOP_BITS(2)) dutOdd2 (
    .CLK(clk), .RST_n(rstN), .Tx_En_Sig(en[1]), .Tx_Data(data[1]),
    .Tx_Done_Sig(done[1]), .Tx_Busy(busy[1]), .TX_Pin_Out(pin[1]));

  uart_tx_engine #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PARITY(2), .STOP_BITS(1)) dutEven1 (
    .CLK(clk), .RST_n(rstN), .Tx_En_Sig(en[2]), .Tx_Data(data[2]),
    .Tx_Done_Sig(done[2]), .Tx_Busy(busy[2]), .TX_Pin_Out(pin[2]));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic enVal, input logic [7:0] dataVal);
    en[sel]   = enVal;
    data[sel] = dataVal;
  endtask

  // Expected line level for frame bit idx, parity derived by counting ones.
  function automatic logic frameBit(input logic [7:0] d, input int parMode, input int idx);
    int ones;
    ones = $countones(d);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && parMode == 1) return (ones % 2 == 0) ? 1'b1 : 1'b0;
    if (idx == 9 && parMode == 2) return (ones % 2 == 1) ? 1'b1 : 1'b0;
    return 1'b1;
  endfunction

  task automatic checkIdle(input int sel, input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s pin%0d", tag, sel), 32'(pin[sel]), 32'd1);
      checkOutput($sformatf("%s busy%0d", tag, sel), 32'(busy[sel]), 32'd0);
      checkOutput($sformatf("%s done%0d", tag, sel), 32'(done[sel]), 32'd0);
    end
  endtask

  // Caller raises En before the start edge; cycle k is sampled on the following negedges.
  task automatic runFrame(input int sel, input logic [7:0] d, input int parMode, input int stops,
                          input int dropCycle, input bit holdEn, input int abortCycle);
    int nbits;
    int last;
    logic expPin;
    nbits = 9 + ((parMode != 0) ? 1 : 0) + stops;
    last  = nbits * BPS + 2;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      expPin = (k <= nbits * BPS) ? frameBit(d, parMode, (k - 1) / BPS) : 1'b1;
      checkOutput($sformatf("pin%0d c%0d", sel, k), 32'(pin[sel]), 32'(expPin));
      checkOutput($sformatf("busy%0d c%0d", sel, k), 32'(busy[sel]), 32'(k <= nbits * BPS + 1));
      checkOutput($sformatf("done%0d c%0d", sel, k), 32'(done[sel]), 32'(k == nbits * BPS + 1));
      if (k == dropCycle) applyStimulus(sel, 1'b0, 8'hFF);
      if (k == nbits * BPS + 1 && !holdEn) applyStimulus(sel, 1'b0, data[sel]);
      if (k == abortCycle) return;
    end
  endtask

  initial begin
    rstN = 1'b0;
    en   = 3'b111;
    for (int i = 0; i < 3; i++) data[i] = 8'hA5;

    // Reset held with requests pending on every instance.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        checkOutput($sformatf("rst pin%0d", s), 32'(pin[s]), 32'd1);
        checkOutput($sformatf("rst busy%0d", s), 32'(busy[s]), 32'd0);
        checkOutput($sformatf("rst done%0d", s), 32'(done[s]), 32'd0);
      end
    end
    rstN = 1'b1;
    applyStimulus(1, 1'b0, 8'h00);
    applyStimulus(2, 1'b0, 8'h00);

    // 8N1 0xA5 starting on the release edge.
    runFrame(0, 8'hA5, 0, 1, 0, 1'b0, 0);
    checkIdle(0, 20, "after8n1");

    // Odd parity with two stop bits, then even parity.
    applyStimulus(1, 1'b1, 8'h07);
    runFrame(1, 8'h07, 1, 2, 0, 1'b0, 0);
    checkIdle(1, 10, "afterOdd");
    applyStimulus(2, 1'b1, 8'h07);
    runFrame(2, 8'h07, 2, 1, 0, 1'b0, 0);
    checkIdle(2, 10, "afterEven");

    // Data and request change mid-frame must not disturb the latched byte.
    applyStimulus(0, 1'b1, 8'h3C);
    runFrame(0, 8'h3C, 0, 1, 40, 1'b0, 0);
    checkIdle(0, 10, "afterMid");

    // Request held through Done: second start bit lands at cycle 163.
    applyStimulus(0, 1'b1, 8'hA5);
    runFrame(0, 8'hA5, 0, 1, 0, 1'b1, 0);
    applyStimulus(0, 1'b1, 8'h5A);
    runFrame(0, 8'h5A, 0, 1, 0, 1'b0, 0);
    checkIdle(0, 20, "afterB2B");

    // Reset during data bit 4 (line low for 0x00), then a clean frame.
    applyStimulus(0, 1'b1, 8'h00);
    runFrame(0, 8'h00, 0, 1, 0, 1'b0, 85);
    rstN = 1'b0;
    applyStimulus(0, 1'b0, 8'h00);
    checkIdle(0, 3, "abortRst");
    rstN = 1'b1;
    checkIdle(0, 20, "abortIdle");
    applyStimulus(0, 1'b1, 8'hC3);
    runFrame(0, 8'hC3, 0, 1, 0, 1'b0, 0);
    checkIdle(0, 5, "afterAbort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
